// File: rtl/game_timer_if.sv
// game_timer_if -- control/status bundle for the game_timer block.
//
// Purpose: groups the mode/direction/clear/load controls and the registered
// count/tick/wrap/running status of game_timer into one port.
//
// Signals:
//   mode      2      00 stop, 01 slow, 10 medium, 11 fast
//   dir       1      0 count up, 1 count down
//   clear     1      synchronous clear (level)
//   load      1      synchronous load strobe
//   load_val  WIDTH  value taken on load
//   count     WIDTH  current count (registered)
//   tick      1      one-cycle pulse on each advance
//   wrap      1      one-cycle pulse when an advance crosses the boundary
//   running   1      registered mode is not stop
//   limit     WIDTH  up-count terminal value   (GAME_TIMER_LIMIT_EN only)
//   done      1      limit reached, advances held (GAME_TIMER_LIMIT_EN only)
//
// Modports: master drives the controls, slave (the timer) drives the status.
// Optional macro: GAME_TIMER_LIMIT_EN adds limit/done.

interface game_timer_if #(
    parameter int WIDTH = 12
);
    logic [1:0]       mode;
    logic             dir;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             wrap;
    logic             running;
`ifdef GAME_TIMER_LIMIT_EN
    logic [WIDTH-1:0] limit;
    logic             done;

    modport master (
        output mode, dir, clear, load, load_val, limit,
        input  count, tick, wrap, running, done
    );

    modport slave (
        input  mode, dir, clear, load, load_val, limit,
        output count, tick, wrap, running, done
    );
`else
    modport master (
        output mode, dir, clear, load, load_val,
        input  count, tick, wrap, running
    );

    modport slave (
        input  mode, dir, clear, load, load_val,
        output count, tick, wrap, running
    );
`endif
endinterface

// File: rtl/game_timer.sv
// game_timer -- prescaled game-tick counter.
//
// Purpose: a speed-mode-selected prescaler produces advances that step a
// WIDTH-bit up/down counter with clear, load, tick and wrap strobes. Used for
// maze game timing from the single system clock; no derived clocks.
//
// Ports:
//   Clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   bus    game_timer_if.slave: mode, dir, clear, load, load_val in;
//          count, tick, wrap, running out (limit in / done out when enabled)
//
// Optional macro: GAME_TIMER_LIMIT_EN -- adds limit/done; once done is set
// advances are suppressed until clear or load.
//
// Speed modes (registered in mode_q):
//   mode | meaning
//   00   | stop: prescaler holds, no advances
//   01   | slow: one advance every DIV_SLOW cycles
//   10   | medium: one advance every DIV_MED cycles
//   11   | fast: one advance every DIV_FAST cycles

module game_timer #(
    parameter int WIDTH      = 12,
    parameter int PRESCALE_W = 8,
    parameter int DIV_SLOW   = 32,
    parameter int DIV_MED    = 16,
    parameter int DIV_FAST   = 8
) (
    input logic          Clk,
    input logic          reset,
    game_timer_if.slave  bus
);

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    // Terminal prescaler values; DIV <= 2^PRESCALE_W so DIV-1 always fits.
    localparam logic [PRESCALE_W-1:0] TC_SLOW = PRESCALE_W'(DIV_SLOW - 1);
    localparam logic [PRESCALE_W-1:0] TC_MED  = PRESCALE_W'(DIV_MED - 1);
    localparam logic [PRESCALE_W-1:0] TC_FAST = PRESCALE_W'(DIV_FAST - 1);

    logic [1:0]            mode_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_nxt;
    logic [PRESCALE_W-1:0] tc_sel;
    logic [WIDTH-1:0]      count_q;
    logic [WIDTH-1:0]      count_nxt;
    logic                  tick_q;
    logic                  wrap_q;
    logic                  mode_chg;
    logic                  at_tc;
    logic                  adv_raw;
    logic                  adv;
    logic                  crosses;
`ifdef GAME_TIMER_LIMIT_EN
    logic                  done_q;
    logic                  hits_end;
`endif

    always_comb begin
        tc_sel = TC_SLOW;
        case (bus.mode)
            MODE_SLOW: tc_sel = TC_SLOW;
            MODE_MED:  tc_sel = TC_MED;
            MODE_FAST: tc_sel = TC_FAST;
            default:   tc_sel = TC_SLOW;
        endcase
    end

    // A mode change restarts the period so a new speed always gets a full
    // period before its first tick.
    assign mode_chg = (bus.mode != mode_q);
    assign at_tc    = (presc_q == tc_sel);
    assign adv_raw  = !mode_chg && (bus.mode != MODE_STOP) && at_tc;

    always_comb begin
        presc_nxt = presc_q + 1'b1;
        if (mode_chg) begin
            presc_nxt = '0;
        end else if (bus.mode == MODE_STOP) begin
            presc_nxt = presc_q;
        end else if (at_tc) begin
            presc_nxt = '0;
        end
    end

    always_comb begin
        count_nxt = bus.dir ? (count_q - 1'b1) : (count_q + 1'b1);
        crosses   = bus.dir ? (count_q == '0) : (&count_q);
    end

`ifdef GAME_TIMER_LIMIT_EN
    // done latches the first advance that lands on the end value and then
    // blocks further advances; the prescaler keeps running underneath.
    assign adv      = adv_raw && !done_q;
    assign hits_end = bus.dir ? (count_nxt == '0) : (count_nxt == bus.limit);
`else
    assign adv = adv_raw;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= MODE_STOP;
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef GAME_TIMER_LIMIT_EN
            done_q  <= 1'b0;
`endif
        end else begin
            mode_q <= bus.mode;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.clear) begin
                count_q <= '0;
                presc_q <= '0;
`ifdef GAME_TIMER_LIMIT_EN
                done_q  <= 1'b0;
`endif
            end else if (bus.load) begin
                count_q <= bus.load_val;
                presc_q <= '0;
`ifdef GAME_TIMER_LIMIT_EN
                done_q  <= 1'b0;
`endif
            end else begin
                presc_q <= presc_nxt;
                if (adv) begin
                    count_q <= count_nxt;
                    tick_q  <= 1'b1;
                    wrap_q  <= crosses;
`ifdef GAME_TIMER_LIMIT_EN
                    done_q  <= hits_end;
`endif
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.running = (mode_q != MODE_STOP);
`ifdef GAME_TIMER_LIMIT_EN
    assign bus.done    = done_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

    logic Clk;
    logic reset;
    int   total;
    int   bad;

    game_timer_if #(.WIDTH(12)) bus ();

    game_timer #(
        .WIDTH(12), .PRESCALE_W(8), .DIV_SLOW(32), .DIV_MED(16), .DIV_FAST(8)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Behavioural model: cycles elapsed in the current period, reset by any
    // restart (mode change, clear, load); an advance happens when the period
    // length for the current speed is reached.
    int m_count;
    int m_elapsed;
    int m_mode;
    int m_div;
    int m_next;
    bit m_adv;
    bit m_tick;
    bit m_wrap;
    bit m_done;

    always @(posedge Clk or negedge reset) begin
        if (!reset) begin
            m_count = 0; m_elapsed = 0; m_mode = 0;
            m_tick = 0; m_wrap = 0; m_done = 0;
        end else begin
            m_adv  = 0;
            m_tick = 0;
            m_wrap = 0;
            m_div  = (bus.mode == 2'd1) ? 32 : (bus.mode == 2'd2) ? 16 : 8;
            if (int'(bus.mode) != m_mode) begin
                m_elapsed = 0;
            end else if (bus.mode != 2'd0) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == m_div) begin
                    m_elapsed = 0;
                    m_adv = 1;
                end
            end
            m_mode = int'(bus.mode);
            if (bus.clear) begin
                m_count = 0; m_elapsed = 0; m_done = 0;
            end else if (bus.load) begin
                m_count = int'(bus.load_val); m_elapsed = 0; m_done = 0;
            end else if (m_adv && !m_done) begin
                m_next  = bus.dir ? m_count - 1 : m_count + 1;
                m_wrap  = (m_next < 0) || (m_next > 4095);
                m_count = (m_next + 4096) % 4096;
                m_tick  = 1;
`ifdef GAME_TIMER_LIMIT_EN
                if (bus.dir ? (m_count == 0) : (m_count == int'(bus.limit)))
                    m_done = 1;
`endif
            end
        end
    end

    always @(negedge Clk) begin
        chk("cyc_count", 32'(bus.count), 32'(m_count));
        chk("cyc_tick", 32'(bus.tick), 32'(m_tick));
        chk("cyc_wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("cyc_running", 32'(bus.running), 32'(m_mode != 0));
`ifdef GAME_TIMER_LIMIT_EN
        chk("cyc_done", 32'(bus.done), 32'(m_done));
`endif
    end

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        int         cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{2'd3, 1'b0, 20};
        vecs[1] = '{2'd3, 1'b1, 30};
        vecs[2] = '{2'd1, 1'b1, 70};
        vecs[3] = '{2'd2, 1'b0, 40};
        vecs[4] = '{2'd0, 1'b0, 10};
        vecs[5] = '{2'd2, 1'b1, 35};
        vecs[6] = '{2'd3, 1'b0, 5};
        vecs[7] = '{2'd1, 1'b0, 40};

        reset = 1'b0;
        bus.mode = 2'd0; bus.dir = 1'b0; bus.clear = 1'b0;
        bus.load = 1'b0; bus.load_val = '0;
`ifdef GAME_TIMER_LIMIT_EN
        bus.limit = 12'h800;
`endif
        step(3);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_running", 32'(bus.running), 32'h0);
        reset = 1'b1;
        step(2);
        chk("idle_count", 32'(bus.count), 32'h0);

        // slow mode: first tick a full 32-cycle period after the mode change
        bus.mode = 2'd1;
        step(1);
        chk("slow_running", 32'(bus.running), 32'h1);
        step(31);
        chk("slow_pre_tick", 32'(bus.tick), 32'h0);
        step(1);
        chk("slow_tick1", 32'(bus.tick), 32'h1);
        chk("slow_count1", 32'(bus.count), 32'h1);
        chk("model_count1", 32'(m_count), 32'h1);
        step(1);
        chk("slow_tick_pulse", 32'(bus.tick), 32'h0);
        step(31);
        chk("slow_tick2", 32'(bus.tick), 32'h1);
        chk("slow_count2", 32'(bus.count), 32'h2);

        // fast mode with load near the top: wrap on the second tick only
        bus.mode = 2'd3; bus.load = 1'b1; bus.load_val = 12'hFFE;
        step(1);
        bus.load = 1'b0;
        chk("load_count", 32'(bus.count), 32'hFFE);
        chk("load_tick", 32'(bus.tick), 32'h0);
        step(7);
        chk("fast_pre_tick", 32'(bus.tick), 32'h0);
        step(1);
        chk("fast_count_fff", 32'(bus.count), 32'hFFF);
        chk("fast_nowrap", 32'(bus.wrap), 32'h0);
        step(8);
        chk("fast_count_000", 32'(bus.count), 32'h0);
        chk("fast_wrap", 32'(bus.wrap), 32'h1);
        step(1);
        chk("fast_wrap_pulse", 32'(bus.wrap), 32'h0);

        // medium mode counting down from 0
        bus.mode = 2'd2; bus.dir = 1'b1;
        step(16);
        chk("med_pre_tick", 32'(bus.tick), 32'h0);
        step(1);
        chk("down_count", 32'(bus.count), 32'hFFF);
        chk("down_wrap", 32'(bus.wrap), 32'h1);
        chk("down_tick", 32'(bus.tick), 32'h1);
        step(1);
        chk("down_wrap_pulse", 32'(bus.wrap), 32'h0);
        chk("down_tick_pulse", 32'(bus.tick), 32'h0);

        // slow -> fast switch at prescaler 20
        bus.mode = 2'd1; bus.dir = 1'b0;
        step(21);
        bus.mode = 2'd3;
        step(8);
        chk("switch_pre_tick", 32'(bus.tick), 32'h0);
        step(1);
        chk("switch_tick", 32'(bus.tick), 32'h1);
        chk("switch_count", 32'(bus.count), 32'h0);

        // stop: count frozen
        bus.mode = 2'd0;
        step(1);
        chk("stop_running", 32'(bus.running), 32'h0);
        step(50);
        chk("stop_count", 32'(bus.count), 32'h0);

        // clear and load together on an advance cycle
        bus.mode = 2'd3; bus.load = 1'b1; bus.load_val = 12'h055;
        step(1);
        bus.load = 1'b0;
        chk("load55", 32'(bus.count), 32'h055);
        step(7);
        bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 12'h123;
        step(1);
        bus.clear = 1'b0; bus.load = 1'b0;
        chk("clr_ld_count", 32'(bus.count), 32'h0);
        chk("clr_ld_tick", 32'(bus.tick), 32'h0);
        step(8);
        chk("after_clr_count", 32'(bus.count), 32'h1);

        // asynchronous reset mid-period
        step(3);
        #1 reset = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_tick", 32'(bus.tick), 32'h0);
        chk("arst_wrap", 32'(bus.wrap), 32'h0);
        chk("arst_running", 32'(bus.running), 32'h0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("rel_running", 32'(bus.running), 32'h1);
        step(7);
        chk("rel_pre_tick", 32'(bus.tick), 32'h0);
        step(1);
        chk("rel_tick", 32'(bus.tick), 32'h1);
        chk("rel_count", 32'(bus.count), 32'h1);

        // mixed patterns checked by the per-cycle model
        for (int i = 0; i < 8; i++) begin
            bus.mode = vecs[i].mode;
            bus.dir  = vecs[i].dir;
            step(vecs[i].cycles);
        end

`ifdef GAME_TIMER_LIMIT_EN
        bus.limit = 12'd3; bus.mode = 2'd3; bus.dir = 1'b0; bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        step(23);
        chk("lim_count2", 32'(bus.count), 32'h2);
        chk("lim_not_done", 32'(bus.done), 32'h0);
        step(1);
        chk("lim_count3", 32'(bus.count), 32'h3);
        chk("lim_done", 32'(bus.done), 32'h1);
        step(16);
        chk("lim_hold", 32'(bus.count), 32'h3);
        chk("lim_notick", 32'(bus.tick), 32'h0);
        bus.load = 1'b1; bus.load_val = 12'h0;
        step(1);
        bus.load = 1'b0;
        chk("lim_done_clr", 32'(bus.done), 32'h0);
        step(8);
        chk("lim_resume", 32'(bus.count), 32'h1);
`endif

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Parametrised prescaled game-tick counter. Successor to the fixed 8/12-bit prescaled register and the 2-bit speed clock divider.
- Speed-mode-selected prescaler generates ticks. Ticks advance a WIDTH-bit up/down counter with load, clear, wrap and tick strobes.
- Drives maze game timing (enemy step rate, score/time display) from the single system clock. No derived clocks.

Parameters:
- WIDTH, 12, counter width in bits (>=2).
- PRESCALE_W, 8, prescaler counter width; all DIV_* values must be <= 2^PRESCALE_W.
- DIV_SLOW, 32, clock cycles per tick in mode 01 (>=1).
- DIV_MED, 16, clock cycles per tick in mode 10 (>=1).
- DIV_FAST, 8, clock cycles per tick in mode 11 (>=1).

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  2  00 stop, 01 slow, 10 medium, 11 fast.
- dir  in  1  0 count up, 1 count down.
- clear  in  1  synchronous clear, level.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken on load.
- count  out  WIDTH  current count, registered.
- tick  out  1  one-cycle pulse on the cycle count advances.
- wrap  out  1  one-cycle pulse when an advance wraps (up: max->0, down: 0->max).
- running  out  1  registered; 1 when the registered mode is not 00.

Behaviour:
- Async reset (reset=0): count=0, prescaler=0, tick=0, wrap=0, running=0, registered mode=00. Reset mid-count discards prescaler progress. The first tick after release needs a full DIV period.
- Divider select: DIV = DIV_SLOW / DIV_MED / DIV_FAST for mode 01/10/11.
- Prescaler, mode 00: prescaler holds its value; no ticks.
- Prescaler, mode change: mode is registered each cycle. If mode differs from the registered mode, the prescaler is forced to 0 and no tick occurs that cycle.
- Prescaler, normal: otherwise, if mode != 00 and prescaler == DIV-1, the prescaler goes to 0 and an advance occurs. Else the prescaler increments.
- DIV=1 gives an advance every cycle.
- Advance: count <= count+1 (dir=0) or count-1 (dir=1), modulo 2^WIDTH. tick=1 that cycle. wrap=1 if the advance crosses the boundary.
- Priority per cycle: clear > load > advance.
  - clear=1: count=0, prescaler=0, tick=0, wrap=0.
  - load=1: count=load_val, prescaler=0, tick=0, wrap=0.
- Latency: tick/wrap are registered and valid in the same cycle the new count is visible. Period in mode 01 with defaults is exactly 32 cycles, tick to tick.
- A dir change takes effect on the next advance. It does not reset the prescaler.
- tick and wrap are never asserted in any cycle where no advance occurred.

Optional Feature:
- Macro: GAME_TIMER_LIMIT_EN.
- Defined: adds ports limit (in, WIDTH) and done (out, 1, reset 0).
  - Up-count: when an advance makes count==limit, done is set.
  - Down-count: when an advance makes count==0, done is set.
  - While done=1, advances are suppressed: count holds, tick=0, wrap=0.
  - done is cleared by clear or load (same cycle, registered).
  - limit is sampled every cycle. Lowering limit below the current count while counting up never sets done until after a wrap.
- Undefined: no limit/done ports. The counter free-runs with wrap only.

Test Plan:
- Reset release, mode=01, dir=0, defaults -> first tick on cycle 32 after release; count 0->1; ticks every 32 cycles; running=1 one cycle after mode set.
- mode=11, load_val=0xFFE, load pulse, dir=0 -> count=0xFFE, ticks after 8 and 16 cycles give 0xFFF then 0x000 with wrap=1 only on the second tick.
- dir=1, count=0, mode=10 -> after 16 cycles count=0xFFF, wrap=1, tick=1; both pulses exactly one cycle.
- Mode switched 01->11 at prescaler=20 -> prescaler forced to 0, next tick exactly 8 cycles after switch cycle; mode=00 -> count frozen, tick=0 indefinitely.
- clear and load asserted together during an advance cycle -> count=0, tick=0; reset driven low mid-period -> all outputs 0 immediately (asynchronously).
- GAME_TIMER_LIMIT_EN, limit=3, mode=11, dir=0 from 0 -> done=1 at count=3 (cycle 24), count holds at 3 and no further ticks; load 0 -> done=0, counting resumes.
